inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder for the RV32I datapath: accepts instruction fields plus a signed 32-bit immediate and packs them into a 32-bit RV32I instruction word, scattering immediate bits exactly as the core's immediate generator expects to gather them. It range-checks and alignment-checks the immediate, assigns each emitted word a sequential instruction-memory byte address, and presents results through a valid/ready stream. It sits between the on-chip program loader/self-test sequencer and the instruction-memory write port.

## Interface

- ADDR_W, 12: width of the instruction-memory byte address; addresses wrap modulo 2^ADDR_W.
- BASE_ADDR, 0: address of the first emitted word; must be a multiple of 4.

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_opcode  in  7  opcode[6:0]
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type, and I-type shifts)
- in_imm  in  32  signed immediate, two's complement
- out_valid  out  1  out_inst/out_addr valid
- out_ready  in  1  consumer accepts output
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address for out_inst
- err_valid  out  1  one-cycle pulse: last accepted bundle rejected
- err_code  out  2  01 unsupported opcode, 10 immediate out of range, 11 immediate misaligned
- err_count  out  8  rejected bundles, saturates at 255

## Operation

- Supported opcodes and packing (bit fields high to low):
  - 0110011 R: funct7, rs2, rs1, funct3, rd, opcode; in_imm ignored, never errors.
  - 0000011 load / 0010011 ALU-imm (I): imm[11:0], rs1, funct3, rd, opcode; range -2048..2047.
  - 0010011 with funct3 001 or 101 (shift): funct7, imm[4:0], rs1, funct3, rd, opcode; range 0..31.
  - 0100011 S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode; range -2048..2047.
  - 1100011 B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode; range -4096..4094, imm[0] must be 0.
  - 1101111 J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode; range -1048576..1048574, imm[0] must be 0.
- Any other opcode: error 01. Check priority: opcode (01), then alignment (11), then range (10).
- Legal bundle: loaded into output register with out_addr = current address counter; counter += 4 (wraps modulo 2^ADDR_W).
- Rejected bundle: no output produced, counter unchanged, err_valid pulses, err_code latched (held until next error or reset), err_count increments unless 255.
- Reset values: out_valid 0, out_inst 0, out_addr 0, err_valid 0, err_code 00, err_count 0, address counter BASE_ADDR.

## Timing

- in_ready = !out_valid || out_ready (combinational from out_ready, no other dependence).
- Accept when in_valid && in_ready at rising edge N; legal result: out_valid = 1 from cycle N+1; latency 1 cycle; throughput 1 word/cycle with out_ready held high.
- Output handshake completes when out_valid && out_ready; out_inst/out_addr held stable while out_valid && !out_ready.
- Simultaneous output handshake and legal accept: output register replaced, out_valid stays 1.
- Simultaneous output handshake and rejected accept: out_valid drops to 0 next cycle.
- err_valid is 1 for exactly the cycle after the rejected accept; back-to-back rejects give consecutive pulses.
- in_valid with in_ready = 0: nothing sampled, no error, no state change.
- reset asserted mid-stream: all state returns to reset values on that edge; bundle presented in the reset cycle is dropped; first bundle after reset gets BASE_ADDR.

## Test plan

- Reset, then opcode 0010011, rd 1, rs1 0, funct3 000, imm 5 -> out_inst 0x00500093, out_addr 0x000 one cycle later.
- Stream with out_ready = 1: S rs1 1, rs2 2, funct3 010, imm 8 -> 0x0020A423 @0x000; B rs1 0, rs2 0, funct3 000, imm -4 -> 0xFE000EE3 @0x004; J rd 1, imm 2048 -> 0x001000EF @0x008; one word per cycle.
- Errors: B imm 3 -> err_code 11; I imm 2048 -> err_code 10; opcode 0110111 -> err_code 01; err_count 3; no out_valid; next legal word gets the unconsumed address.
- Backpressure: out_ready = 0 for 5 cycles with in_valid held -> in_ready 0, out_inst stable; release -> held bundle accepted, addresses contiguous, none lost or duplicated.
- Wrap and saturation: ADDR_W 4, 5 legal words -> addresses 0x0,0x4,0x8,0xC,0x0; 300 rejects -> err_count 255.
- Reset asserted while out_valid = 1 and counter at 0x010 -> out_valid 0, err_count 0, next word at BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs instruction fields and a signed immediate into a
// 32-bit word, validates the immediate, and streams words with sequential byte addresses.
`timescale 1ns/1ps

module inst_encoder #(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_OPCODE = 2'b01,
    ERR_RANGE  = 2'b10,
    ERR_ALIGN  = 2'b11
  } errCode_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic              outValid_q, outValid_d;
  logic [31:0]       outInst_q, outInst_d;
  logic [ADDR_W-1:0] outAddr_q, outAddr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              errValid_q, errValid_d;
  errCode_e          errCode_q, errCode_d;
  logic [7:0]        errCount_q, errCount_d;

  logic signed [31:0] immS;
  logic               isShift;
  logic               accept;
  logic [31:0]        encInst;
  errCode_e           encErr;

  function automatic logic inRange(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign immS     = $signed(in_imm);
  assign isShift  = (in_opcode == OP_IMM) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Pack fields per format; alignment is checked before range so odd offsets report misalignment.
  always_comb begin
    encInst = '0;
    encErr  = ERR_NONE;
    case (in_opcode)
      OP_R: begin
        encInst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_LOAD, OP_IMM: begin
        if (isShift) begin
          encInst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          if (!inRange(immS, 0, 31)) encErr = ERR_RANGE;
        end else begin
          encInst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          if (!inRange(immS, -2048, 2047)) encErr = ERR_RANGE;
        end
      end
      OP_STORE: begin
        encInst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (!inRange(immS, -2048, 2047)) encErr = ERR_RANGE;
      end
      OP_BRANCH: begin
        encInst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
        if (in_imm[0])                        encErr = ERR_ALIGN;
        else if (!inRange(immS, -4096, 4094)) encErr = ERR_RANGE;
      end
      OP_JAL: begin
        encInst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (in_imm[0])                              encErr = ERR_ALIGN;
        else if (!inRange(immS, -1048576, 1048574)) encErr = ERR_RANGE;
      end
      default: encErr = ERR_OPCODE;
    endcase
  end

  // A rejected accept alongside an output handshake lets out_valid fall.
  always_comb begin
    outValid_d = outValid_q;
    outInst_d  = outInst_q;
    outAddr_d  = outAddr_q;
    addr_d     = addr_q;
    errValid_d = 1'b0;
    errCode_d  = errCode_q;
    errCount_d = errCount_q;
    if (accept && (encErr == ERR_NONE)) begin
      outValid_d = 1'b1;
      outInst_d  = encInst;
      outAddr_d  = addr_q;
      addr_d     = addr_q + ADDR_W'(4);
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
    if (accept && (encErr != ERR_NONE)) begin
      errValid_d = 1'b1;
      errCode_d  = encErr;
      if (errCount_q != 8'hFF) errCount_d = errCount_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      outInst_q  <= '0;
      outAddr_q  <= '0;
      addr_q     <= BASE_ADDR;
      errValid_q <= 1'b0;
      errCode_q  <= ERR_NONE;
      errCount_q <= '0;
    end else begin
      outValid_q <= outValid_d;
      outInst_q  <= outInst_d;
      outAddr_q  <= outAddr_d;
      addr_q     <= addr_d;
      errValid_q <= errValid_d;
      errCode_q  <= errCode_d;
      errCount_q <= errCount_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_inst  = outInst_q;
  assign out_addr  = outAddr_q;
  assign err_valid = errValid_q;
  assign err_code  = errCode_q;
  assign err_count = errCount_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: expected words are queued when driven and
// compared when the output handshake fires; a 4-bit-address twin checks wrap.
`timescale 1ns/1ps

module tb_inst_encoder;

  typedef struct packed {
    logic [31:0] inst;
    logic [11:0] addr;
  } sbEntry_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready4;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [31:0] out_inst, out_inst4;
  logic [11:0] out_addr;
  logic [3:0]  out_addr4;
  logic        err_valid, err_valid4;
  logic [1:0]  err_code, err_code4;
  logic [7:0]  err_count, err_count4;

  int          checkCount = 0;
  int          passCount  = 0;
  int          lastWait   = 0;
  logic [11:0] expAddr    = '0;
  logic [3:0]  expAddr4   = '0;
  sbEntry_t    sbQueue[$];

  inst_encoder #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .err_valid(err_valid), .err_code(err_code),
    .err_count(err_count)
  );

  inst_encoder #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid4), .out_ready(out_ready), .out_inst(out_inst4),
    .out_addr(out_addr4), .err_valid(err_valid4), .err_code(err_code4),
    .err_count(err_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  function automatic logic [31:0] iWord(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [11:0] imm);
    return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
  endfunction

  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid  = 1'b1;
  endtask

  task automatic waitAccept();
    bit ok = 0;
    lastWait = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      lastWait++;
    end
    if (!ok) begin
      checkCount++;
      $error("[TB] FAIL accept_timeout: observed in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sendLegal(input string tag, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] expInst);
    sbEntry_t e;
    applyStimulus(op, rd, rs1, rs2, f3, f7, imm);
    e.inst = expInst;
    e.addr = expAddr;
    sbQueue.push_back(e);
    expAddr = expAddr + 12'd4;
    waitAccept();
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, "_addr4"}, {28'b0, out_addr4}, {28'b0, expAddr4});
    expAddr4 = expAddr4 + 4'd4;
  endtask

  task automatic sendReject(input string tag, input logic [6:0] op, input logic [31:0] imm,
                            input logic [2:0] f3, input logic [1:0] expCode);
    applyStimulus(op, 5'd1, 5'd2, 5'd3, f3, 7'd0, imm);
    waitAccept();
    checkOutput({tag, "_errv"}, {31'b0, err_valid}, 32'd1);
    checkOutput({tag, "_code"}, {30'b0, err_code}, {30'b0, expCode});
  endtask

  task automatic resetDut();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sbQueue.delete();
    expAddr  = '0;
    expAddr4 = '0;
    reset    = 1'b0;
  endtask

  // Scoreboard: pop one expected word per completed output handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sbQueue.size() == 0) begin
        checkCount++;
        $error("[TB] FAIL sb_unexpected: observed word 0x%08h expected none", out_inst);
      end else begin
        sbEntry_t e;
        e = sbQueue.pop_front();
        checkOutput("sb_inst", out_inst, e.inst);
        checkOutput("sb_addr", {20'b0, out_addr}, {20'b0, e.addr});
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_inst", out_inst, 32'd0);
    checkOutput("rst_out_addr", {20'b0, out_addr}, 32'd0);
    checkOutput("rst_err_valid", {31'b0, err_valid}, 32'd0);
    checkOutput("rst_err_code", {30'b0, err_code}, 32'd0);
    checkOutput("rst_err_count", {24'b0, err_count}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;

    $display("[TB] stream and 4-bit wrap");
    sendLegal("addi", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h00500093);
    sendLegal("sw", 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423);
    checkOutput("stream_wait_sw", 32'(lastWait), 32'd0);
    sendLegal("beq", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd4, 32'hFE000EE3);
    checkOutput("stream_wait_beq", 32'(lastWait), 32'd0);
    sendLegal("jal", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h001000EF);
    checkOutput("stream_wait_jal", 32'(lastWait), 32'd0);
    sendLegal("add", 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEADBEEF, 32'h002081B3);

    $display("[TB] error reporting");
    sendReject("b_odd", 7'b1100011, 32'd3, 3'b000, 2'b11);
    checkOutput("b_odd_noout", {31'b0, out_valid}, 32'd0);
    sendReject("i_big", 7'b0010011, 32'd2048, 3'b000, 2'b10);
    checkOutput("i_big_noout", {31'b0, out_valid}, 32'd0);
    sendReject("lui", 7'b0110111, 32'd0, 3'b000, 2'b01);
    checkOutput("err_count3", {24'b0, err_count}, 32'd3);
    @(posedge clk); #1;
    checkOutput("err_pulse_end", {31'b0, err_valid}, 32'd0);
    checkOutput("err_code_held", {30'b0, err_code}, 32'd1);
    sendReject("j_odd_far", 7'b1101111, 32'd1048577, 3'b000, 2'b11);
    sendReject("shift_32", 7'b0010011, 32'd32, 3'b101, 2'b10);
    sendReject("shift_neg", 7'b0010011, -32'sd1, 3'b001, 2'b10);
    sendReject("j_big", 7'b1101111, 32'd1048576, 3'b000, 2'b10);
    sendReject("i_low", 7'b0000011, -32'sd2049, 3'b010, 2'b10);
    sendReject("b_big", 7'b1100011, 32'd4096, 3'b000, 2'b10);
    checkOutput("err_count9", {24'b0, err_count}, 32'd9);

    $display("[TB] legal boundaries");
    sendLegal("lw", 7'b0000011, 5'd5, 5'd6, 5'd0, 3'b010, 7'd0, -32'sd4, 32'hFFC32283);
    sendLegal("b_max", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4094, 32'h7E000FE3);
    sendLegal("b_min", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd4096, 32'h80000063);
    sendLegal("j_min", 7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd1048576, 32'h8000006F);
    sendLegal("i_min", 7'b0010011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2048, 32'h80000013);
    sendLegal("srai", 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd3, 32'h40315093);

    $display("[TB] backpressure");
    sendLegal("bp_a", 7'b0010011, 5'd7, 5'd7, 5'd0, 3'b000, 7'd0, 32'd7, iWord(5'd7, 5'd7, 3'b000, 12'd7));
    out_ready = 1'b0;
    begin
      sbEntry_t e;
      applyStimulus(7'b0010011, 5'd8, 5'd8, 5'd0, 3'b000, 7'd0, 32'd8);
      e.inst = iWord(5'd8, 5'd8, 3'b000, 12'd8);
      e.addr = expAddr;
      sbQueue.push_back(e);
      expAddr = expAddr + 12'd4;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("bp_stable", out_inst, iWord(5'd7, 5'd7, 3'b000, 12'd7));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitAccept();
    expAddr4 = expAddr4 + 4'd4;
    checkOutput("bp_b_inst", out_inst, iWord(5'd8, 5'd8, 3'b000, 12'd8));
    sendLegal("bp_c", 7'b0010011, 5'd9, 5'd9, 5'd0, 3'b000, 7'd0, 32'd9, iWord(5'd9, 5'd9, 3'b000, 12'd9));
    sendLegal("bp_d", 7'b0010011, 5'd10, 5'd1, 5'd0, 3'b000, 7'd0, 32'd10, iWord(5'd10, 5'd1, 3'b000, 12'd10));

    $display("[TB] reset mid-stream");
    resetDut();
    for (int w = 0; w < 4; w++) begin
      sendLegal("rs_fill", 7'b0010011, 5'(w), 5'd0, 5'd0, 3'b000, 7'd0, 32'(w),
                iWord(5'(w), 5'd0, 3'b000, 12'(w)));
    end
    sendReject("rs_rej", 7'b0110111, 32'd0, 3'b000, 2'b01);
    out_ready = 1'b0;
    sendLegal("rs_held", 7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4, iWord(5'd4, 5'd0, 3'b000, 12'd4));
    checkOutput("rs_held_addr", {20'b0, out_addr}, 32'h010);
    checkOutput("rs_pre_errcnt", {24'b0, err_count}, 32'd1);
    reset = 1'b1;
    applyStimulus(7'b0010011, 5'd9, 5'd0, 5'd0, 3'b000, 7'd0, 32'd9);
    @(posedge clk); #1;
    checkOutput("rs_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rs_err_count", {24'b0, err_count}, 32'd0);
    checkOutput("rs_err_code", {30'b0, err_code}, 32'd0);
    checkOutput("rs_out_addr", {20'b0, out_addr}, 32'd0);
    sbQueue.delete();
    expAddr = '0; expAddr4 = '0;
    in_valid = 1'b0; reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("rs_dropped", {31'b0, out_valid}, 32'd0);
    sendLegal("rs_first", 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, iWord(5'd2, 5'd0, 3'b000, 12'd1));

    $display("[TB] error count saturation");
    for (int r = 0; r < 254; r++) begin
      applyStimulus(7'b0110111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0);
      waitAccept();
    end
    checkOutput("sat_254", {24'b0, err_count}, 32'd254);
    sendReject("sat_255", 7'b0110111, 32'd0, 3'b000, 2'b01);
    checkOutput("sat_255_cnt", {24'b0, err_count}, 32'd255);
    for (int r = 0; r < 45; r++) begin
      applyStimulus(7'b0110111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0);
      waitAccept();
    end
    checkOutput("sat_300", {24'b0, err_count}, 32'd255);
    sendLegal("post_sat", 7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, iWord(5'd3, 5'd0, 3'b000, 12'd3));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
